// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
//   state_t     : controller FSM encoding (RUN, MEM_WAIT, MEM_ERR)
//   TIMEOUT_DEF : default maximum number of MEM_WAIT cycles before error
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MEM_ERR  = 2'd2
  } state_t;

  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the instruction in ID.
// Ports:
//   id_rs, id_rt   : ID source registers
//   id_usesRt      : ID instruction actually reads rt
//   ex_memRead     : EX instruction is a load
//   ex_rd          : EX destination register
//   load_use       : hazard present (r0 never creates one)
module hazard_detect (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_usesRt,
  input  logic       ex_memRead,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  assign load_use = ex_memRead && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs) || (id_usesRt && (ex_rd == id_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with data-memory wait handling.
// Ports:
//   clock, reset          : clock, async active-low reset
//   id_*, ex_*, mem_*     : hazard sources from ID, EX and MEM stages
//   pcWrite..exMemWrite   : stage-register write enables
//   ifIdFlush, idExFlush  : bubble insertion into IF/ID, ID/EX
//   memWbBubble           : MEM/WB captures zeros while memory is frozen
//   memError              : sticky memory timeout flag (MEM_ERR state)
//   stallCount            : saturating count of cycles with pcWrite=0
// Priority of actions: memory freeze > taken branch > load-use > normal.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_usesRt,
  input  logic        ex_memRead,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branchTaken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pcWrite,
  output logic        ifIdWrite,
  output logic        idExWrite,
  output logic        exMemWrite,
  output logic        ifIdFlush,
  output logic        idExFlush,
  output logic        memWbBubble,
  output logic        memError,
  output logic [15:0] stallCount
);

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [15:0] stall_cnt;
  logic        load_use;
  logic        freeze;

  hazard_detect u_hazard (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_usesRt  (id_usesRt),
    .ex_memRead (ex_memRead),
    .ex_rd      (ex_rd),
    .load_use   (load_use)
  );

  // The MEM_WAIT cycle where mem_ready rises is not frozen: the pipeline
  // advances on that edge together with the return to RUN.
  assign freeze = (state == ST_MEM_ERR) ||
                  ((state == ST_MEM_WAIT) && !mem_ready) ||
                  ((state == ST_RUN) && mem_req && !mem_ready);

  always_comb begin
    pcWrite     = 1'b1;
    ifIdWrite   = 1'b1;
    idExWrite   = 1'b1;
    exMemWrite  = 1'b1;
    ifIdFlush   = 1'b0;
    idExFlush   = 1'b0;
    memWbBubble = 1'b0;
    if (freeze) begin
      pcWrite     = 1'b0;
      ifIdWrite   = 1'b0;
      idExWrite   = 1'b0;
      exMemWrite  = 1'b0;
      memWbBubble = 1'b1;
    end else if (ex_branchTaken) begin
      // ID holds a wrong-path instruction, so any load-use on it is moot.
      ifIdFlush = 1'b1;
      idExFlush = 1'b1;
    end else if (load_use) begin
      pcWrite   = 1'b0;
      ifIdWrite = 1'b0;
      idExFlush = 1'b1;
    end
  end

  assign memError   = (state == ST_MEM_ERR);
  assign stallCount = stall_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_RUN;
      wait_cnt  <= 8'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (!pcWrite && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      case (state)
        ST_RUN: begin
          if (mem_req && !mem_ready) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= 8'd0;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready)
            state <= ST_RUN;
          else if (wait_cnt == TO)
            state <= ST_MEM_ERR;
          else
            wait_cnt <= wait_cnt + 8'd1;
        end
        ST_MEM_ERR: state <= ST_MEM_ERR;
        default:    state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_usesRt, ex_memRead, ex_branchTaken, mem_req, mem_ready;
  logic        pcWrite, ifIdWrite, idExWrite, exMemWrite;
  logic        ifIdFlush, idExFlush, memWbBubble, memError;
  logic [15:0] stallCount;

  always #5 clock = ~clock;

  pipeline_ctrl #(.TIMEOUT(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_usesRt      (id_usesRt),
    .ex_memRead     (ex_memRead),
    .ex_rd          (ex_rd),
    .ex_branchTaken (ex_branchTaken),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .pcWrite        (pcWrite),
    .ifIdWrite      (ifIdWrite),
    .idExWrite      (idExWrite),
    .exMemWrite     (exMemWrite),
    .ifIdFlush      (ifIdFlush),
    .idExFlush      (idExFlush),
    .memWbBubble    (memWbBubble),
    .memError       (memError),
    .stallCount     (stallCount)
  );

  // {pcWrite,ifIdWrite,idExWrite,exMemWrite,ifIdFlush,idExFlush,memWbBubble,memError}
  localparam logic [7:0] O_NORM = 8'hF0;
  localparam logic [7:0] O_LU   = 8'h34;
  localparam logic [7:0] O_BR   = 8'hFC;
  localparam logic [7:0] O_FRZ  = 8'h02;
  localparam logic [7:0] O_ERR  = 8'h03;

  typedef struct {
    string       name;
    logic [7:0]  outs;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Monitor: every negedge with a pending expectation, compare the DUT.
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e = q.pop_front();
      act = {pcWrite, ifIdWrite, idExWrite, exMemWrite,
             ifIdFlush, idExFlush, memWbBubble, memError};
      checks++;
      if (act !== e.outs) begin
        errors++;
        $display("FAIL %s outs: got %02h expected %02h", e.name, act, e.outs);
      end
      checks++;
      if (stallCount !== e.cnt) begin
        errors++;
        $display("FAIL %s stallCount: got %04h expected %04h", e.name, stallCount, e.cnt);
      end
    end
  end

  // One cycle of stimulus: drive just after posedge, queue the expectation.
  task automatic step(input string name, input logic rst, input logic frc,
                      input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic mrd, input logic [4:0] rd, input logic br,
                      input logic mreq, input logic mrdy,
                      input logic [7:0] eo, input logic [15:0] ec);
    exp_t e;
    @(posedge clock);
    #1;
    if (frc) begin
      force dut.stall_cnt = 16'hFFFE;
      #1;
      release dut.stall_cnt;
    end
    reset = rst;
    id_rs = rs; id_rt = rt; id_usesRt = urt;
    ex_memRead = mrd; ex_rd = rd; ex_branchTaken = br;
    mem_req = mreq; mem_ready = mrdy;
    e.name = name; e.outs = eo; e.cnt = ec;
    q.push_back(e);
  endtask

  initial begin
    reset = 1'b0;
    id_rs = '0; id_rt = '0; id_usesRt = 1'b0; ex_memRead = 1'b0;
    ex_rd = '0; ex_branchTaken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    //    name          rst frc rs  rt urt mrd rd br mreq rdy  outs    cnt
    step("reset",       0, 0, 0,  0, 0, 0,  0, 0, 0, 0, O_NORM, 16'd0);
    step("no_haz",      1, 0, 1,  2, 0, 1,  3, 0, 0, 0, O_NORM, 16'd0);
    step("lu_rs",       1, 0, 5,  0, 0, 1,  5, 0, 0, 0, O_LU,   16'd0);
    step("after_lu",    1, 0, 0,  0, 0, 0,  0, 0, 0, 0, O_NORM, 16'd1);
    step("r0_no_lu",    1, 0, 0,  0, 0, 1,  0, 0, 0, 0, O_NORM, 16'd1);
    step("rt_unused",   1, 0, 1,  7, 0, 1,  7, 0, 0, 0, O_NORM, 16'd1);
    step("lu_rt",       1, 0, 1,  7, 1, 1,  7, 0, 0, 0, O_LU,   16'd1);
    step("norm2",       1, 0, 0,  0, 0, 0,  0, 0, 0, 0, O_NORM, 16'd2);
    step("br_over_lu",  1, 0, 5,  0, 0, 1,  5, 1, 0, 0, O_BR,   16'd2);
    step("frz_over_br", 1, 0, 5,  0, 0, 1,  5, 1, 1, 0, O_FRZ,  16'd2);
    step("frz_wait1",   1, 0, 5,  0, 0, 1,  5, 1, 1, 0, O_FRZ,  16'd3);
    step("frz_wait2",   1, 0, 5,  0, 0, 1,  5, 1, 1, 0, O_FRZ,  16'd4);
    step("br_after_frz",1, 0, 5,  0, 0, 1,  5, 1, 1, 1, O_BR,   16'd5);
    step("norm3",       1, 0, 0,  0, 0, 0,  0, 0, 0, 0, O_NORM, 16'd5);
    // three-cycle memory wait, advance on the fourth
    step("mw_run",      1, 0, 0,  0, 0, 0,  0, 0, 1, 0, O_FRZ,  16'd5);
    step("mw_1",        1, 0, 0,  0, 0, 0,  0, 0, 1, 0, O_FRZ,  16'd6);
    step("mw_2",        1, 0, 0,  0, 0, 0,  0, 0, 1, 0, O_FRZ,  16'd7);
    step("mw_ready",    1, 0, 0,  0, 0, 0,  0, 0, 1, 1, O_NORM, 16'd8);
    step("mw_back_run", 1, 0, 0,  0, 0, 0,  0, 0, 0, 0, O_NORM, 16'd8);
    // ready arrives exactly when counter == TIMEOUT: no error
    step("to_edge_0",   1, 0, 0,  0, 0, 0,  0, 0, 1, 0, O_FRZ,  16'd8);
    step("to_edge_1",   1, 0, 0,  0, 0, 0,  0, 0, 1, 0, O_FRZ,  16'd9);
    step("to_edge_2",   1, 0, 0,  0, 0, 0,  0, 0, 1, 0, O_FRZ,  16'd10);
    step("to_edge_3",   1, 0, 0,  0, 0, 0,  0, 0, 1, 0, O_FRZ,  16'd11);
    step("to_edge_4",   1, 0, 0,  0, 0, 0,  0, 0, 1, 0, O_FRZ,  16'd12);
    step("to_edge_rdy", 1, 0, 0,  0, 0, 0,  0, 0, 1, 1, O_NORM, 16'd13);
    // ready never arrives: timeout into MEM_ERR
    step("to_0",        1, 0, 0,  0, 0, 0,  0, 0, 1, 0, O_FRZ,  16'd13);
    step("to_1",        1, 0, 0,  0, 0, 0,  0, 0, 1, 0, O_FRZ,  16'd14);
    step("to_2",        1, 0, 0,  0, 0, 0,  0, 0, 1, 0, O_FRZ,  16'd15);
    step("to_3",        1, 0, 0,  0, 0, 0,  0, 0, 1, 0, O_FRZ,  16'd16);
    step("to_4",        1, 0, 0,  0, 0, 0,  0, 0, 1, 0, O_FRZ,  16'd17);
    step("to_expire",   1, 0, 0,  0, 0, 0,  0, 0, 1, 0, O_FRZ,  16'd18);
    step("err_sticky1", 1, 0, 0,  0, 0, 0,  0, 0, 0, 1, O_ERR,  16'd19);
    step("err_sticky2", 1, 0, 5,  0, 0, 1,  5, 1, 0, 1, O_ERR,  16'd20);
    // reset out of MEM_ERR; outputs follow RUN decoding while held
    step("rst_from_err",0, 0, 5,  0, 0, 1,  5, 0, 0, 0, O_LU,   16'd0);
    step("rst_br",      0, 0, 5,  0, 0, 1,  5, 1, 0, 0, O_BR,   16'd0);
    step("post_rst",    1, 0, 0,  0, 0, 0,  0, 0, 0, 0, O_NORM, 16'd0);
    // reset in the middle of a memory wait
    step("mw_pre_rst",  1, 0, 0,  0, 0, 0,  0, 0, 1, 0, O_FRZ,  16'd0);
    step("mw_rst",      0, 0, 0,  0, 0, 0,  0, 0, 0, 0, O_NORM, 16'd0);
    step("mw_post_rst", 1, 0, 0,  0, 0, 0,  0, 0, 0, 0, O_NORM, 16'd0);
    // saturation
    step("sat_fffe",    1, 1, 5,  0, 0, 1,  5, 0, 0, 0, O_LU,   16'hFFFE);
    step("sat_ffff",    1, 0, 5,  0, 0, 1,  5, 0, 0, 0, O_LU,   16'hFFFF);
    step("sat_hold",    1, 0, 0,  0, 0, 0,  0, 0, 0, 0, O_NORM, 16'hFFFF);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, max MEM_WAIT cycles before error (1..255).
REQ-002 clock  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 id_rs, id_rt  input  5 each  source registers of instruction in ID.
REQ-005 id_usesRt  input  1  ID instruction reads rt.
REQ-006 ex_memRead  input  1  instruction in EX is a load.
REQ-007 ex_rd  input  5  destination of instruction in EX.
REQ-008 ex_branchTaken  input  1  branch/jump resolved taken in EX.
REQ-009 mem_req  input  1  instruction in MEM accesses data memory.
REQ-010 mem_ready  input  1  data memory completes access this cycle.
REQ-011 pcWrite, ifIdWrite, idExWrite, exMemWrite  output  1 each  stage-register enables.
REQ-012 ifIdFlush, idExFlush  output  1 each  load bubble into IF/ID, ID/EX.
REQ-013 memWbBubble  output  1  MEM/WB loads zeros (regWrite=0).
REQ-014 memError  output  1  sticky timeout flag.
REQ-015 stallCount  output  16  saturating count of cycles with pcWrite=0.

Function
REQ-016 FSM states RUN, MEM_WAIT, MEM_ERR; state, wait counter, stallCount registered; all other outputs combinational from state and inputs.
REQ-017 RUN -> MEM_WAIT when mem_req=1 and mem_ready=0; RUN stays otherwise.
REQ-018 MEM_WAIT -> RUN when mem_ready=1; -> MEM_ERR when wait counter equals TIMEOUT and mem_ready=0; else stay, counter +1.
REQ-019 Wait counter (8 bits) cleared on every RUN -> MEM_WAIT transition.
REQ-020 MEM_ERR is terminal until reset; memError=1 only in MEM_ERR.
REQ-021 Memory freeze (MEM_WAIT, MEM_ERR, or RUN with mem_req=1 and mem_ready=0): pcWrite=ifIdWrite=idExWrite=exMemWrite=0, memWbBubble=1, flushes=0.
REQ-022 Load-use hazard = ex_memRead and ex_rd!=0 and (ex_rd==id_rs or (id_usesRt and ex_rd==id_rt)).
REQ-023 Load-use without freeze/branch: pcWrite=0, ifIdWrite=0, idExFlush=1, idExWrite=1, exMemWrite=1, memWbBubble=0.
REQ-024 ex_branchTaken without freeze: ifIdFlush=1, idExFlush=1, pcWrite=1; load-use ignored (wrong-path).
REQ-025 Priority: freeze > branch > load-use > normal.
REQ-026 Normal: all write enables 1, flushes 0, memWbBubble 0.
REQ-027 In MEM_WAIT the cycle where mem_ready=1 is not frozen; pipeline advances that edge.
REQ-028 Freeze holds EX inputs constant, so a branch or load-use pending during freeze is re-evaluated when freeze ends.
REQ-029 stallCount increments each cycle pcWrite=0, saturates at 16'hFFFF.

Reset
REQ-030 reset=0 asynchronously forces state=RUN, wait counter=0, stallCount=0, memError=0.
REQ-031 Reset mid-MEM_WAIT or in MEM_ERR returns to RUN with no residual freeze.
REQ-032 During reset combinational outputs follow RUN decoding of current inputs.

Structure
REQ-033 Shared package holds state encoding (2-bit: RUN=0, MEM_WAIT=1, MEM_ERR=2) and TIMEOUT default.
REQ-034 One sub-module hazard_detect (combinational load-use compare, REQ-022); FSM and counters in pipeline_ctrl.

Verification
REQ-035 ex_memRead=1, ex_rd=5, id_rs=5, no mem_req -> one cycle pcWrite=0, ifIdWrite=0, idExFlush=1; stallCount=1.
REQ-036 ex_rd=0, ex_memRead=1, id_rs=0 -> no stall; id_usesRt=0, id_rt=ex_rd=7 -> no stall.
REQ-037 mem_req=1, mem_ready low 3 cycles then high -> freeze 3 cycles, advance on 4th; stallCount=3; state back to RUN.
REQ-038 TIMEOUT=4, mem_ready held 0 -> MEM_ERR entered, memError=1 persistent; reset low -> RUN, memError=0, stallCount=0.
REQ-039 Same cycle ex_branchTaken=1 and load-use -> ifIdFlush=1, idExFlush=1, pcWrite=1; with mem_req=1, mem_ready=0 also -> freeze only.
REQ-040 Force stallCount to 16'hFFFE, two stall cycles -> holds 16'hFFFF.
